// File: rtl/if_fetch_ctrl_pkg.sv
// Shared types and constants for the instruction-fetch controller.
// The optional FETCH_ALIGN_CHECK_EN build adds misaligned-redirect detection in the top.
package if_fetch_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_REQ     = 2'd0,
        ST_WAIT    = 2'd1,
        ST_HOLD    = 2'd2,
        ST_DISCARD = 2'd3
    } fetch_state_e;

    localparam logic [31:0] RESET_PC_DEF  = 32'h0000_3000;
    localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0000;
    localparam int          IF_ID_W       = 65;

    function automatic logic [31:0] pc_inc(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/if_fetch_ctrl_if.sv
// Instruction-memory request/ready bus between the fetch controller and memory.
interface if_fetch_ctrl_if;
    logic        req;
    logic [31:0] addr;
    logic        ready;
    logic [31:0] rdata;

    modport master (output req, output addr, input ready, input rdata);
    modport slave  (input req, input addr, output ready, output rdata);
endinterface

// File: rtl/if_fetch_ctrl_if_id_reg.sv
// IF/ID pipeline register: {instruction, pc+4, valid} with flush > hold > load priority.
module if_id_reg #(
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        flush,
    input  logic        hold,
    input  logic [31:0] d_instr,
    input  logic [31:0] d_pc4,
    output logic [31:0] q_instr,
    output logic [31:0] q_pc4,
    output logic        q_valid
);
    import if_fetch_ctrl_pkg::*;

    localparam logic [IF_ID_W-1:0] EMPTY = {NOP_INSTR, 32'd0, 1'b0};

    logic [IF_ID_W-1:0] data_q, data_d;

    always_comb begin
        data_d = data_q;
        if (flush)
            data_d = EMPTY;
        else if (!hold && load)
            data_d = {d_instr, d_pc4, 1'b1};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            data_q <= EMPTY;
        else
            data_q <= data_d;
    end

    assign {q_instr, q_pc4, q_valid} = data_q;
endmodule

// File: rtl/if_fetch_ctrl.sv
// Fetch controller: owns the PC, drives the imem handshake and fills IF/ID.
// Define FETCH_ALIGN_CHECK_EN to add a sticky misalign_err and word-align redirect targets.
module if_fetch_ctrl
    import if_fetch_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = RESET_PC_DEF,
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [31:0]        npc_in,
    input  logic               redirect,
    input  logic               stall,
    if_fetch_ctrl_if.master    imem,
    output logic [31:0]        pc_add_out,
    output logic [31:0]        IF_ID_im_out,
    output logic [31:0]        IF_ID_pc_add_out,
`ifdef FETCH_ALIGN_CHECK_EN
    output logic               misalign_err,
`endif
    output logic               IF_ID_valid
);
    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic         hold_valid_q, hold_valid_d;
    logic [31:0]  hold_instr_q, hold_instr_d;
    logic [31:0]  hold_pc4_q, hold_pc4_d;
    logic [31:0]  redirect_pc;
    logic         req, beat;
    logic         ifid_load, ifid_flush;
    logic [31:0]  ifid_instr, ifid_pc4;

`ifdef FETCH_ALIGN_CHECK_EN
    logic misalign_q, misalign_d;
    assign redirect_pc  = {npc_in[31:2], 2'b00};
    assign misalign_err = misalign_q;
`else
    assign redirect_pc  = npc_in;
`endif

    // Request is forced low while reset is held so memory sees the abandon.
    always_comb begin
        req = 1'b0;
        unique case (state_q)
            ST_REQ:     req = !stall;
            ST_WAIT:    req = 1'b1;
            ST_HOLD:    req = 1'b0;
            ST_DISCARD: req = 1'b1;
            default:    req = 1'b0;
        endcase
        if (rst)
            req = 1'b0;
    end

    assign beat       = req && imem.ready;
    assign imem.req   = req;
    assign imem.addr  = pc_q;
    assign pc_add_out = pc_inc(pc_q);

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        hold_valid_d = hold_valid_q;
        hold_instr_d = hold_instr_q;
        hold_pc4_d   = hold_pc4_q;
        ifid_load    = 1'b0;
        ifid_flush   = 1'b0;
        ifid_instr   = imem.rdata;
        ifid_pc4     = pc_add_out;
`ifdef FETCH_ALIGN_CHECK_EN
        misalign_d   = misalign_q;
`endif
        if (redirect) begin
            pc_d         = redirect_pc;
            ifid_flush   = 1'b1;
            hold_valid_d = 1'b0;
            state_d      = (req && !imem.ready) ? ST_DISCARD : ST_REQ;
`ifdef FETCH_ALIGN_CHECK_EN
            if (npc_in[1:0] != 2'b00)
                misalign_d = 1'b1;
`endif
        end else begin
            unique case (state_q)
                ST_REQ, ST_WAIT: begin
                    if (beat) begin
                        pc_d = pc_add_out;
                        if (stall) begin
                            hold_valid_d = 1'b1;
                            hold_instr_d = imem.rdata;
                            hold_pc4_d   = pc_add_out;
                            state_d      = ST_HOLD;
                        end else begin
                            ifid_load = 1'b1;
                            state_d   = ST_REQ;
                        end
                    end else if (!stall && req) begin
                        state_d = ST_WAIT;
                    end
                end
                ST_HOLD: begin
                    if (!stall) begin
                        ifid_load    = hold_valid_q;
                        ifid_instr   = hold_instr_q;
                        ifid_pc4     = hold_pc4_q;
                        hold_valid_d = 1'b0;
                        state_d      = ST_REQ;
                    end
                end
                ST_DISCARD: begin
                    if (beat)
                        state_d = ST_REQ;
                end
                default: state_d = ST_REQ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_REQ;
            pc_q         <= RESET_PC;
            hold_valid_q <= 1'b0;
            hold_instr_q <= NOP_INSTR;
            hold_pc4_q   <= 32'd0;
`ifdef FETCH_ALIGN_CHECK_EN
            misalign_q   <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            hold_valid_q <= hold_valid_d;
            hold_instr_q <= hold_instr_d;
            hold_pc4_q   <= hold_pc4_d;
`ifdef FETCH_ALIGN_CHECK_EN
            misalign_q   <= misalign_d;
`endif
        end
    end

    if_id_reg #(.NOP_INSTR(NOP_INSTR)) u_if_id (
        .clk     (clk),
        .rst     (rst),
        .load    (ifid_load),
        .flush   (ifid_flush),
        .hold    (stall),
        .d_instr (ifid_instr),
        .d_pc4   (ifid_pc4),
        .q_instr (IF_ID_im_out),
        .q_pc4   (IF_ID_pc_add_out),
        .q_valid (IF_ID_valid)
    );
endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Bench for if_fetch_ctrl: directed cycles feed a scoreboard of expected IF/ID loads.
module tb_if_fetch_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] npc_in = 32'd0;
    logic        redirect = 1'b0;
    logic        stall = 1'b0;
    logic [31:0] pc_add_out, IF_ID_im_out, IF_ID_pc_add_out;
    logic        IF_ID_valid;
`ifdef FETCH_ALIGN_CHECK_EN
    logic        misalign_err;
`endif

    int n_cmp = 0;
    int n_bad = 0;
    logic [63:0] exp_q[$];

    if_fetch_ctrl_if bus ();

    if_fetch_ctrl dut (
        .clk              (clk),
        .rst              (rst),
        .npc_in           (npc_in),
        .redirect         (redirect),
        .stall            (stall),
        .imem             (bus),
        .pc_add_out       (pc_add_out),
        .IF_ID_im_out     (IF_ID_im_out),
        .IF_ID_pc_add_out (IF_ID_pc_add_out),
`ifdef FETCH_ALIGN_CHECK_EN
        .misalign_err     (misalign_err),
`endif
        .IF_ID_valid      (IF_ID_valid)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h5A5A_0000;
    endfunction

    assign bus.rdata = mem_word(bus.addr);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end else
            $display("ok   %s: %h", name, act);
    endtask

    task automatic push(input logic [31:0] addr);
        exp_q.push_back({mem_word(addr), addr + 32'd4});
    endtask

    task automatic cyc(input logic s, input logic r, input logic [31:0] n, input logic rdy,
                       input logic exp_req, input logic [31:0] exp_addr, input string tag);
        @(negedge clk);
        stall = s; redirect = r; npc_in = n; bus.ready = rdy;
        #1;
        chk({tag, " req"}, {31'd0, bus.req}, {31'd0, exp_req});
        chk({tag, " addr"}, bus.addr, exp_addr);
    endtask

    // Monitor: every fresh valid IF/ID content must match the next expected load.
    initial begin
        logic [63:0] cur, last;
        logic        last_valid;
        last = '0;
        last_valid = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            cur = {IF_ID_im_out, IF_ID_pc_add_out};
            if (IF_ID_valid && (!last_valid || cur != last)) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL ifid_unexpected: got %h expected none", cur);
                end else begin
                    logic [63:0] e;
                    e = exp_q.pop_front();
                    if (cur !== e) begin
                        n_bad++;
                        $display("FAIL ifid_load: got %h expected %h", cur, e);
                    end else
                        $display("ok   ifid_load: %h", cur);
                end
            end
            last = cur;
            last_valid = IF_ID_valid;
        end
    end

    initial begin
        bus.ready = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst req", {31'd0, bus.req}, 32'd0);
        chk("rst addr", bus.addr, 32'h3000);
        chk("rst valid", {31'd0, IF_ID_valid}, 32'd0);
        chk("rst im", IF_ID_im_out, 32'd0);
        chk("rst pc4", IF_ID_pc_add_out, 32'd0);
        rst = 1'b0;

        // Zero-wait streaming
        cyc(0, 0, 0, 1, 1, 32'h3000, "s1a"); push(32'h3000);
        cyc(0, 0, 0, 1, 1, 32'h3004, "s1b"); push(32'h3004);
        chk("s1 valid", {31'd0, IF_ID_valid}, 32'd1);
        cyc(0, 0, 0, 1, 1, 32'h3008, "s1c"); push(32'h3008);
        // Memory wait states
        cyc(0, 0, 0, 0, 1, 32'h300C, "s2a");
        chk("s2 ifid held", IF_ID_pc_add_out, 32'h300C);
        cyc(0, 0, 0, 0, 1, 32'h300C, "s2b");
        cyc(0, 0, 0, 0, 1, 32'h300C, "s2c");
        cyc(0, 0, 0, 1, 1, 32'h300C, "s2d"); push(32'h300C);
        // Stall during a beat
        cyc(0, 0, 0, 0, 1, 32'h3010, "s3a");
        cyc(1, 0, 0, 1, 1, 32'h3010, "s3b");
        chk("s3 ifid old", IF_ID_pc_add_out, 32'h3010);
        cyc(1, 0, 0, 1, 0, 32'h3014, "s3c");
        chk("s3 ifid still", IF_ID_pc_add_out, 32'h3010);
        cyc(0, 0, 0, 1, 0, 32'h3014, "s3d"); push(32'h3010);
        cyc(0, 0, 0, 1, 1, 32'h3014, "s3e"); push(32'h3014);
        chk("s3 released", IF_ID_pc_add_out, 32'h3014);
        // Redirect while waiting
        cyc(0, 0, 0, 0, 1, 32'h3018, "s4a");
        cyc(0, 1, 32'h3100, 0, 1, 32'h3018, "s4b");
        cyc(0, 0, 0, 1, 1, 32'h3100, "s4c");
        chk("s4 valid", {31'd0, IF_ID_valid}, 32'd0);
        chk("s4 im", IF_ID_im_out, 32'd0);
        cyc(0, 0, 0, 1, 1, 32'h3100, "s4d"); push(32'h3100);
        chk("s4 discarded", {31'd0, IF_ID_valid}, 32'd0);
        // Redirect plus stall in HOLD
        cyc(0, 0, 0, 0, 1, 32'h3104, "s5a");
        cyc(1, 0, 0, 1, 1, 32'h3104, "s5b");
        cyc(1, 1, 32'h3200, 1, 0, 32'h3108, "s5c");
        cyc(0, 0, 0, 1, 1, 32'h3200, "s5d"); push(32'h3200);
        chk("s5 flushed", {31'd0, IF_ID_valid}, 32'd0);
        // Redirect with coincident beat, then PC wrap
        cyc(0, 1, 32'hFFFF_FFFC, 1, 1, 32'h3204, "s6a");
        cyc(0, 0, 0, 1, 1, 32'hFFFF_FFFC, "s6b"); push(32'hFFFF_FFFC);
        chk("s6 wrap pc4", pc_add_out, 32'd0);
        chk("s6 dropped", {31'd0, IF_ID_valid}, 32'd0);
        cyc(0, 0, 0, 1, 1, 32'h0000_0000, "s6c"); push(32'h0);
        cyc(1, 0, 0, 1, 0, 32'h0000_0004, "s6d");
        cyc(1, 0, 0, 1, 0, 32'h0000_0004, "s6e");
        chk("s6 last", IF_ID_pc_add_out, 32'd4);
`ifdef FETCH_ALIGN_CHECK_EN
        chk("s7 clean", {31'd0, misalign_err}, 32'd0);
        cyc(0, 1, 32'h3102, 0, 1, 32'h0000_0004, "s7a");
        cyc(1, 0, 0, 1, 1, 32'h3100, "s7b");
        chk("s7 err", {31'd0, misalign_err}, 32'd1);
        cyc(1, 0, 0, 1, 0, 32'h3100, "s7c");
        chk("s7 sticky", {31'd0, misalign_err}, 32'd1);
        cyc(0, 0, 0, 0, 1, 32'h3100, "s8a");
`else
        cyc(0, 0, 0, 0, 1, 32'h0000_0004, "s8a");
`endif
        // Reset while a request is outstanding
        #2 rst = 1'b1;
        #1;
        chk("s8 req drop", {31'd0, bus.req}, 32'd0);
        chk("s8 addr", bus.addr, 32'h3000);
        chk("s8 valid", {31'd0, IF_ID_valid}, 32'd0);
`ifdef FETCH_ALIGN_CHECK_EN
        chk("s8 err clr", {31'd0, misalign_err}, 32'd0);
`endif
        repeat (3) @(negedge clk);
        chk("queue empty", exp_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
